// File: rtl/matrix_op_scheduler.sv
// matrix_op_scheduler
// Shares one 4x4 elementwise matrix engine among NUM_REQ requesters.
// A round-robin arbiter picks a requester. The block pulses the engine start
// and waits for done, or aborts with an error after TIMEOUT cycles. It then
// returns a tagged response. eng_sel and eng_op stay stable from grant until
// the response is consumed, so the operand muxes stay on the granted source.
module matrix_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    eng_start,
  output logic [OP_W-1:0]         eng_op,
  output logic [IDW-1:0]          eng_sel,
  input  logic                    eng_done,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_err,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam int                IDX_W    = IDW + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [IDW-1:0]    LAST_RST = IDW'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]  NUM_IDX  = IDX_W'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [IDW-1:0]    sel_q, sel_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // Arbiter results
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [OP_W-1:0]   grant_op;
  logic [IDX_W-1:0]  cand_w;
  logic [IDW-1:0]    cand;

  // Per-requester opcode view of the flat req_op bus
  logic [OP_W-1:0]   op_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op_slice
      assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
    end
  endgenerate

  // Round-robin search: first valid requester after last_grant, wrapping mod NUM_REQ
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    cand_w       = '0;
    cand         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_w = {1'b0, last_grant_q} + IDX_W'(i + 1);
      if (cand_w >= NUM_IDX) begin
        cand_w = cand_w - NUM_IDX;
      end
      cand = cand_w[IDW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found        = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
    grant_op = op_arr[grant_idx];
  end

  // Next-state and per-state outputs of the scheduling FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    req_ready    = '0;
    eng_start    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // Gated by rst_n so no accept pulse is shown while reset is held
        if (grant_found && rst_n) begin
          req_ready = grant_onehot;
          sel_d     = grant_idx;
          op_d      = grant_op;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        err_d     = 1'b0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
        // cnt_q == 0 is the first WAIT cycle: done may be stale from the last op
        if ((cnt_q != '0) && eng_done) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          last_grant_d = sel_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_RST;
      sel_q        <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign eng_sel = sel_q;
  assign eng_op  = op_q;
  assign rsp_id  = rsp_valid ? sel_q : '0;
  assign rsp_err = rsp_valid & err_q;

endmodule
